cpu_clk_ctrl: RTL and testbench



---
 rtl/cpu_clk_pkg.sv | 28 ++
 rtl/cpu_clk_ctrl_if.sv | 30 +++
 rtl/cpu_clk_ctrl_debounce.sv | 55 +++++
 rtl/cpu_clk_ctrl.sv | 158 +++++++++++++++
 tb/tb_cpu_clk_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_clk_pkg.sv
// Shared types and default sizing for the CPU clock/run controller.
package cpu_clk_pkg;

  localparam int unsigned DEF_DIV_WIDTH       = 16;
  localparam int unsigned DEF_DEFAULT_DIV     = 100;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000;
  localparam int unsigned DEF_BURST_WIDTH     = 16;
  localparam int unsigned DEF_CNT_WIDTH       = 32;

  typedef enum logic [1:0] {
    MODE_HALT  = 2'b00,
    MODE_RUN   = 2'b01,
    MODE_STEP  = 2'b10,
    MODE_BURST = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    PARKED = 2'b00,
    HIGH   = 2'b01,
    LOW    = 2'b10
  } state_e;

  // Modes in which step/burst grants are live.
  function automatic logic grant_mode(input mode_e m);
    return (m == MODE_STEP) || (m == MODE_BURST);
  endfunction

endpackage

// File: rtl/cpu_clk_ctrl_if.sv
// Control/status bundle between the board-level controls and the clock controller.
interface cpu_clk_ctrl_if
  import cpu_clk_pkg::*;
#(
  parameter int unsigned DIV_WIDTH   = DEF_DIV_WIDTH,
  parameter int unsigned BURST_WIDTH = DEF_BURST_WIDTH,
  parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH
);

  mode_e                  mode;
  logic [DIV_WIDTH-1:0]   div;
  logic                   div_load;
  logic                   step_btn;
  logic [BURST_WIDTH-1:0] burst_len;
  logic                   clk_out;
  logic                   clk_en;
  logic                   running;
  logic [CNT_WIDTH-1:0]   cycle_count;

  modport master (
    output mode, div, div_load, step_btn, burst_len,
    input  clk_out, clk_en, running, cycle_count
  );

  modport slave (
    input  mode, div, div_load, step_btn, burst_len,
    output clk_out, clk_en, running, cycle_count
  );

endinterface

// File: rtl/cpu_clk_ctrl_debounce.sv
// Button synchroniser and debouncer; emits a one-cycle press on the debounced rising edge.
module button_debounce
  import cpu_clk_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic sysclk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  logic w_differs;
  logic w_accept;

  assign w_differs = (r_sync2 != r_level);
  assign w_accept  = w_differs && (r_cnt == CNT_LAST);

  // Two-flop synchroniser, then count consecutive cycles of disagreement.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
      r_press <= w_accept && r_sync2;
      if (w_accept) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else if (w_differs) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign level = r_level;
  assign press = r_press;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// CPU clock generator: programmable 50% divider gated by run/halt/step/burst modes.
module cpu_clk_ctrl
  import cpu_clk_pkg::*;
#(
  parameter int unsigned DIV_WIDTH       = DEF_DIV_WIDTH,
  parameter int unsigned DEFAULT_DIV     = DEF_DEFAULT_DIV,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned BURST_WIDTH     = DEF_BURST_WIDTH,
  parameter int unsigned CNT_WIDTH       = DEF_CNT_WIDTH
) (
  input  logic           sysclk,
  input  logic           reset,
  cpu_clk_ctrl_if.slave  bus
);

  localparam logic [DIV_WIDTH-1:0] DIV_RESET = DIV_WIDTH'(DEFAULT_DIV);

  state_e                 r_state;
  logic [DIV_WIDTH-1:0]   r_half_cnt;
  logic [DIV_WIDTH-1:0]   r_div_q;
  logic [BURST_WIDTH-1:0] r_grants;
  logic                   r_clk_out;
  logic                   r_clk_en;
  logic                   r_running;
  logic [CNT_WIDTH-1:0]   r_cycle_count;

  state_e                 w_state_nxt;
  logic [DIV_WIDTH-1:0]   w_half_nxt;
  logic [DIV_WIDTH-1:0]   w_div_nxt;
  logic [BURST_WIDTH-1:0] w_grants_eff;
  logic [BURST_WIDTH-1:0] w_grants_nxt;
  logic                   w_clk_out_nxt;
  logic                   w_fire;
  logic                   w_gate_open;
  logic                   w_half_last;
  logic                   w_btn_level;
  logic                   w_btn_press;
  logic                   w_press_acc;

  button_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_step_btn (
    .sysclk  (sysclk),
    .reset   (reset),
    .btn_raw (bus.step_btn),
    .level   (w_btn_level),
    .press   (w_btn_press)
  );

  // Grants only survive in STEP/BURST; leaving to RUN/HALT drops them immediately.
  assign w_grants_eff = grant_mode(bus.mode) ? r_grants : '0;
  assign w_gate_open  = (bus.mode == MODE_RUN) || (w_grants_eff != '0);
  assign w_half_last  = (r_half_cnt == (r_div_q - DIV_WIDTH'(1)));
  assign w_press_acc  = w_btn_press && w_btn_level;

  // Next state of the divider FSM; a load always restarts the half-period count.
  always_comb begin
    w_state_nxt   = r_state;
    w_half_nxt    = r_half_cnt;
    w_clk_out_nxt = r_clk_out;
    w_fire        = 1'b0;
    case (r_state)
      PARKED: begin
        w_clk_out_nxt = 1'b0;
        w_half_nxt    = '0;
        w_fire        = w_gate_open;
      end
      HIGH: begin
        if (w_half_last) begin
          w_clk_out_nxt = 1'b0;
          w_half_nxt    = '0;
          w_state_nxt   = LOW;
        end else begin
          w_half_nxt = r_half_cnt + DIV_WIDTH'(1);
        end
      end
      LOW: begin
        if (w_half_last) begin
          w_half_nxt = '0;
          if (w_gate_open) begin
            w_fire = 1'b1;
          end else begin
            w_state_nxt   = PARKED;
            w_clk_out_nxt = 1'b0;
          end
        end else begin
          w_half_nxt = r_half_cnt + DIV_WIDTH'(1);
        end
      end
      default: begin
        w_state_nxt   = PARKED;
        w_clk_out_nxt = 1'b0;
        w_half_nxt    = '0;
      end
    endcase
    if (w_fire) begin
      w_clk_out_nxt = 1'b1;
      w_half_nxt    = '0;
      w_state_nxt   = HIGH;
    end
    if (bus.div_load) begin
      w_half_nxt = '0;
    end
  end

  // Grant bookkeeping: consumption beats a new press; presses never accumulate.
  always_comb begin
    w_grants_nxt = w_grants_eff;
    if (w_fire && (w_grants_eff != '0)) begin
      w_grants_nxt = w_grants_eff - BURST_WIDTH'(1);
    end else if (w_press_acc && (w_grants_eff == '0)) begin
      if (bus.mode == MODE_STEP) begin
        w_grants_nxt = BURST_WIDTH'(1);
      end else if (bus.mode == MODE_BURST) begin
        w_grants_nxt = bus.burst_len;
      end
    end
  end

  // Divisor capture; zero behaves as one.
  always_comb begin
    w_div_nxt = r_div_q;
    if (bus.div_load) begin
      w_div_nxt = (bus.div == '0) ? DIV_WIDTH'(1) : bus.div;
    end
  end

  // State and output registers.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_state       <= PARKED;
      r_half_cnt    <= '0;
      r_div_q       <= DIV_RESET;
      r_grants      <= '0;
      r_clk_out     <= 1'b0;
      r_clk_en      <= 1'b0;
      r_running     <= 1'b0;
      r_cycle_count <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_half_cnt <= w_half_nxt;
      r_div_q    <= w_div_nxt;
      r_grants   <= w_grants_nxt;
      r_clk_out  <= w_clk_out_nxt;
      r_clk_en   <= w_fire;
      r_running  <= (bus.mode == MODE_RUN) || (w_grants_nxt != '0);
      if (w_fire) begin
        r_cycle_count <= r_cycle_count + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.clk_out     = r_clk_out;
  assign bus.clk_en      = r_clk_en;
  assign bus.running     = r_running;
  assign bus.cycle_count = r_cycle_count;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Scoreboard bench for cpu_clk_ctrl: each expected clk_en pulse is queued with its cycle_count and spacing.
module tb_cpu_clk_ctrl;
  import cpu_clk_pkg::*;

  typedef struct {
    int unsigned count;
    int unsigned gap;   // 0 = spacing not checked
  } exp_t;

  logic        sysclk = 1'b0;
  logic        reset  = 1'b1;
  int unsigned cyc    = 0;
  int unsigned last_en_cyc = 0;
  int unsigned en_seen = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  exp_t        sb_q[$];

  cpu_clk_ctrl_if #(.DIV_WIDTH(16), .BURST_WIDTH(16), .CNT_WIDTH(32)) bus ();

  cpu_clk_ctrl #(
    .DIV_WIDTH       (16),
    .DEFAULT_DIV     (100),
    .DEBOUNCE_CYCLES (4),
    .BURST_WIDTH     (16),
    .CNT_WIDTH       (32)
  ) dut (
    .sysclk (sysclk),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input int unsigned count, input int unsigned gap);
    exp_t e;
    e.count = count;
    e.gap   = gap;
    sb_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sysclk);
    #1;
  endtask

  task automatic wait_en(input int unsigned target, input int budget);
    int k = 0;
    while (en_seen < target && k < budget) begin
      @(negedge sysclk);
      #1;
      k++;
    end
    if (en_seen < target) check("wait_en_timeout", en_seen, target);
  endtask

  task automatic drive_btn(input logic lvl, input int n);
    bus.step_btn = lvl;
    tick(n);
  endtask

  task automatic load_div(input int unsigned d);
    bus.div      = 16'(d);
    bus.div_load = 1'b1;
    tick(1);
    bus.div_load = 1'b0;
  endtask

  // Pop one expectation per observed clk_en pulse.
  always @(negedge sysclk) begin
    if (bus.clk_en === 1'b1) begin
      exp_t e;
      en_seen++;
      check("en_with_clk_out_high", bus.clk_out, 1);
      check("en_was_expected", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("cycle_count_at_en", bus.cycle_count, e.count);
        if (e.gap != 0) check("en_spacing", cyc - last_en_cyc, e.gap);
      end
      last_en_cyc = cyc;
    end
  end

  initial begin
    bus.mode      = MODE_RUN;
    bus.div       = '0;
    bus.div_load  = 1'b0;
    bus.step_btn  = 1'b0;
    bus.burst_len = '0;
    tick(5);
    check("rst_clk_out", bus.clk_out, 0);
    check("rst_clk_en", bus.clk_en, 0);
    check("rst_cycle_count", bus.cycle_count, 0);
    check("rst_running", bus.running, 0);

    // 1: free run at default divisor, first pulse right after reset release.
    push(1, 1);
    for (int i = 2; i <= 5; i++) push(i, 200);
    last_en_cyc = cyc;
    reset = 1'b0;
    wait_en(5, 1000);
    check("run_count5", bus.cycle_count, 5);
    check("run_running", bus.running, 1);
    tick(99);
    check("run_high_end", bus.clk_out, 1);
    tick(1);
    check("run_low_start", bus.clk_out, 0);
    bus.mode = MODE_HALT;
    tick(110);
    check("halt_parked", bus.clk_out, 0);

    // 2: divisor reload mid-phase, zero divisor, and load on a terminal count.
    bus.mode = MODE_RUN;
    push(6, 0); push(7, 17); push(8, 6); push(9, 6);
    wait_en(6, 10);
    tick(10);
    load_div(3);
    wait_en(9, 60);
    push(10, 3); push(11, 2); push(12, 2);
    load_div(0);
    wait_en(12, 20);
    push(13, 5);
    bus.div      = 16'd4;
    bus.div_load = 1'b1;
    tick(1);
    bus.div_load = 1'b0;
    check("load_at_terminal_falls", bus.clk_out, 0);
    wait_en(13, 20);
    bus.mode = MODE_HALT;
    tick(12);
    check("t2_parked", bus.clk_out, 0);
    check("t2_running", bus.running, 0);

    // 3: single step from a bouncy button.
    bus.mode = MODE_STEP;
    push(14, 0);
    drive_btn(1, 2); drive_btn(0, 1); drive_btn(1, 3); drive_btn(0, 2);
    drive_btn(1, 10); drive_btn(0, 20);
    wait_en(14, 50);
    check("step_count", bus.cycle_count, 14);
    check("step_parked", bus.clk_out, 0);
    check("step_running", bus.running, 0);

    // 4: burst of three at divisor 2, then zero-length burst, then press while pending.
    bus.mode      = MODE_BURST;
    bus.burst_len = 16'd3;
    load_div(2);
    push(15, 0); push(16, 4); push(17, 4);
    drive_btn(1, 10);
    check("burst_running", bus.running, 1);
    drive_btn(0, 20);
    wait_en(17, 50);
    check("burst_parked", bus.clk_out, 0);
    check("burst_done_running", bus.running, 0);
    bus.burst_len = '0;
    drive_btn(1, 10); drive_btn(0, 20);
    check("burst0_no_en", en_seen, 17);
    bus.burst_len = 16'd3;
    load_div(20);
    push(18, 0); push(19, 40); push(20, 40);
    drive_btn(1, 10); drive_btn(0, 20); drive_btn(1, 10); drive_btn(0, 20);
    wait_en(20, 200);
    tick(50);
    check("no_accumulate", en_seen, 20);
    check("no_acc_parked", bus.clk_out, 0);

    // 5: halt mid-high, then grants dropped on the way to RUN.
    bus.mode = MODE_RUN;
    push(21, 0);
    wait_en(21, 10);
    tick(5);
    bus.mode = MODE_HALT;
    tick(14);
    check("halt_keeps_high", bus.clk_out, 1);
    tick(1);
    check("halt_falls_at_term", bus.clk_out, 0);
    tick(40);
    check("halt_no_en", en_seen, 21);
    bus.mode      = MODE_BURST;
    bus.burst_len = 16'd5;
    push(22, 0); push(23, 40); push(24, 40); push(25, 40);
    drive_btn(1, 10); drive_btn(0, 5);
    wait_en(22, 20);
    bus.mode = MODE_STEP;
    wait_en(23, 60);
    bus.mode = MODE_RUN;
    wait_en(25, 100);
    bus.mode = MODE_STEP;
    tick(60);
    check("grants_cleared", en_seen, 25);
    check("grants_cleared_parked", bus.clk_out, 0);
    check("grants_cleared_running", bus.running, 0);

    // 6: reset during HIGH after a divisor load restores defaults.
    bus.mode = MODE_RUN;
    push(26, 0);
    wait_en(26, 10);
    load_div(7);
    tick(2);
    reset    = 1'b1;
    bus.mode = MODE_HALT;
    tick(1);
    check("rst_mid_clk_out", bus.clk_out, 0);
    check("rst_mid_clk_en", bus.clk_en, 0);
    check("rst_mid_count", bus.cycle_count, 0);
    check("rst_mid_running", bus.running, 0);
    reset = 1'b0;
    tick(3);
    check("post_rst_parked", bus.clk_out, 0);
    bus.mode = MODE_RUN;
    push(1, 0); push(2, 200);
    wait_en(28, 300);
    bus.mode = MODE_HALT;
    tick(205);
    check("final_en_total", en_seen, 28);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
